// File: rtl/nx_node_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : nx_node_core_seq
// Brief    : Sequential logic-node engine. Fetches 3-input LUT instructions,
//            executes them into working registers and commits staged outputs.
// Revision : 1.0 - initial release
// ============================================================================
module nx_node_core_seq #(
    parameter int INPUTS     = 32,
    parameter int OUTPUTS    = 32,
    parameter int REGISTERS  = 16,
    parameter int RAM_ADDR_W = 10,
    parameter int RAM_DATA_W = 32,
    parameter int RD_LATENCY = 2,
    parameter int OUT_MODE   = 0,
    parameter int TRIG_DEPTH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [INPUTS-1:0]     i_inputs,
    output logic [OUTPUTS-1:0]    o_outputs,
    input  logic [RAM_ADDR_W-1:0] i_base_addr,
    input  logic [RAM_ADDR_W-1:0] i_populated,
    input  logic                  i_trigger,
    output logic                  o_idle,
    output logic                  o_done,
    output logic [RAM_ADDR_W-1:0] o_instr_addr,
    output logic                  o_instr_rd_en,
    input  logic [RAM_DATA_W-1:0] i_instr_rd_data,
    input  logic                  i_instr_stall
);

    localparam int SRC_N    = (INPUTS > REGISTERS) ? INPUTS : REGISTERS;
    localparam int SRC_W    = $clog2(SRC_N);
    localparam int REG_W    = $clog2(REGISTERS);
    localparam int OUT_W    = $clog2(OUTPUTS);
    localparam int IDX_W    = (OUT_MODE == 1) ? OUT_W : 0;
    localparam int INSTR_W  = 8 + 3 * (SRC_W + 1) + REG_W + 1 + IDX_W;
    localparam int c_SRC_N2 = 1 << SRC_W;

    localparam int c_A_LSB  = 8;
    localparam int c_A_IP   = c_A_LSB + SRC_W;
    localparam int c_B_LSB  = c_A_IP + 1;
    localparam int c_B_IP   = c_B_LSB + SRC_W;
    localparam int c_C_LSB  = c_B_IP + 1;
    localparam int c_C_IP   = c_C_LSB + SRC_W;
    localparam int c_TGT    = c_C_IP + 1;
    localparam int c_GEN    = c_TGT + REG_W;
    localparam int c_OIDX   = c_GEN + 1;

    localparam logic [2:0]       c_PEND_MAX = 3'(TRIG_DEPTH);
    localparam logic [OUT_W-1:0] c_SEQ_MAX  = OUT_W'(OUTPUTS - 1);

    if (INSTR_W > RAM_DATA_W) begin : g_err_instr_w
        $error("nx_node_core_seq: instruction width exceeds RAM_DATA_W");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_err_latency
        $error("nx_node_core_seq: RD_LATENCY must be 1..4");
    end
    if (TRIG_DEPTH < 1 || TRIG_DEPTH > 7) begin : g_err_trig_depth
        $error("nx_node_core_seq: TRIG_DEPTH must be 1..7");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t                  r_state;
    logic [RAM_ADDR_W-1:0]   r_pc;
    logic [RAM_ADDR_W-1:0]   r_base;
    logic [RAM_ADDR_W-1:0]   r_pop;
    logic [RAM_ADDR_W-1:0]   r_addr;
    logic                    r_rd_en;
    logic [2:0]              r_pend;
    logic [RD_LATENCY-1:0]   r_vsr;
    logic [REGISTERS-1:0]    r_work;
    logic [OUTPUTS-1:0]      r_staged;
    logic [OUTPUTS-1:0]      r_out;
    logic                    r_done;
    logic [OUT_W-1:0]        r_seq;

    logic [RD_LATENCY-1:0]   w_vsr_next;
    logic [c_SRC_N2-1:0]     w_in_pad;
    logic [SRC_W-1:0]        w_src_a, w_src_b, w_src_c;
    logic                    w_a, w_b, w_c;
    logic                    w_res;
    logic                    w_exec;
    logic                    w_gen;
    logic [REG_W-1:0]        w_tgt;
    logic [OUT_W-1:0]        w_oidx;
    logic                    w_oidx_ok;
    logic                    w_start;
    logic                    w_unused;

    if (RD_LATENCY == 1) begin : g_vsr_one
        assign w_vsr_next = r_rd_en;
    end else begin : g_vsr_multi
        assign w_vsr_next = {r_vsr[RD_LATENCY-2:0], r_rd_en};
    end

    if (OUT_MODE == 1) begin : g_oidx_field
        assign w_oidx = i_instr_rd_data[c_OIDX +: OUT_W];
    end else begin : g_oidx_seq
        assign w_oidx = r_seq;
    end

    // Input indices past INPUTS read as 0 via zero-extension.
    assign w_in_pad = c_SRC_N2'(i_inputs);

    always_comb begin
        w_src_a   = i_instr_rd_data[c_A_LSB +: SRC_W];
        w_src_b   = i_instr_rd_data[c_B_LSB +: SRC_W];
        w_src_c   = i_instr_rd_data[c_C_LSB +: SRC_W];
        w_a       = i_instr_rd_data[c_A_IP] ? w_in_pad[w_src_a] : r_work[w_src_a[REG_W-1:0]];
        w_b       = i_instr_rd_data[c_B_IP] ? w_in_pad[w_src_b] : r_work[w_src_b[REG_W-1:0]];
        w_c       = i_instr_rd_data[c_C_IP] ? w_in_pad[w_src_c] : r_work[w_src_c[REG_W-1:0]];
        w_res     = i_instr_rd_data[{w_a, w_b, w_c}];
        w_tgt     = i_instr_rd_data[c_TGT +: REG_W];
        w_gen     = i_instr_rd_data[c_GEN];
        w_oidx_ok = ({1'b0, w_oidx} < (OUT_W + 1)'(OUTPUTS));
        w_exec    = r_vsr[RD_LATENCY-1] && !i_instr_stall;
        w_start   = (r_state == S_IDLE) && (i_trigger || (r_pend != 3'd0));
    end

    assign w_unused = &{1'b0, i_instr_rd_data, r_seq};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_base   <= '0;
            r_pop    <= '0;
            r_addr   <= '0;
            r_rd_en  <= 1'b0;
            r_pend   <= 3'd0;
            r_vsr    <= '0;
            r_work   <= '0;
            r_staged <= '0;
            r_out    <= '0;
            r_done   <= 1'b0;
            r_seq    <= '0;
        end else begin
            r_done <= 1'b0;

            if (!i_instr_stall) begin
                r_vsr <= w_vsr_next;
            end

            if (w_exec) begin
                r_work[w_tgt] <= w_res;
                if (w_gen) begin
                    if (w_oidx_ok) begin
                        r_staged[w_oidx] <= w_res;
                    end
                    r_seq <= (r_seq == c_SEQ_MAX) ? '0 : r_seq + 1'b1;
                end
            end

            if (i_trigger && (r_state != S_IDLE) && (r_pend != c_PEND_MAX)) begin
                r_pend <= r_pend + 3'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_base <= i_base_addr;
                        r_pop  <= i_populated;
                        r_seq  <= '0;
                        if (!i_trigger) begin
                            r_pend <= r_pend - 3'd1;
                        end
                        if (i_populated == '0) begin
                            r_state <= S_COMMIT;
                            r_done  <= 1'b1;
                            r_out   <= r_staged;
                        end else if (!i_instr_stall) begin
                            // First fetch is issued on the start edge itself.
                            r_addr  <= i_base_addr;
                            r_rd_en <= 1'b1;
                            r_pc    <= RAM_ADDR_W'(1);
                            r_state <= (i_populated == RAM_ADDR_W'(1)) ? S_DRAIN : S_FETCH;
                        end else begin
                            r_pc    <= '0;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (!i_instr_stall) begin
                        r_addr  <= r_base + r_pc;
                        r_rd_en <= 1'b1;
                        r_pc    <= r_pc + RAM_ADDR_W'(1);
                        if (r_pc == r_pop - RAM_ADDR_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!i_instr_stall) begin
                        r_rd_en <= 1'b0;
                    end
                    if ((r_vsr == '0) && !r_rd_en) begin
                        r_state <= S_COMMIT;
                        r_done  <= 1'b1;
                        r_out   <= r_staged;
                        r_pc    <= '0;
                    end
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_outputs     = r_out;
    assign o_done        = r_done;
    assign o_instr_addr  = r_addr;
    assign o_instr_rd_en = r_rd_en;
    assign o_idle        = (r_state == S_IDLE) && (r_pend == 3'd0);

endmodule
`default_nettype wire
